// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: level codes, PAL/NTSC line counts and
// line ranges, and the line-type enum used by the sync generator.
package video_timing_pkg;

   localparam logic [2:0] LVL_SYNC  = 3'b000;
   localparam logic [2:0] LVL_BLACK = 3'b001;
   localparam logic [2:0] LVL_GRAY0 = 3'b010;
   localparam logic [2:0] LVL_GRAY1 = 3'b011;
   localparam logic [2:0] LVL_GRAY2 = 3'b100;
   localparam logic [2:0] LVL_GRAY3 = 3'b101;
   localparam logic [2:0] LVL_GRAY4 = 3'b110;
   localparam logic [2:0] LVL_GRAY5 = 3'b111;

   localparam logic [8:0] PAL_LINES  = 9'd312;
   localparam logic [8:0] NTSC_LINES = 9'd262;

   // Last line (inclusive) of each region
   localparam logic [8:0] PAL_BROAD_LAST    = 9'd1;
   localparam logic [8:0] PAL_BS_LINE       = 9'd2;
   localparam logic [8:0] PAL_SHORT_LAST    = 9'd4;
   localparam logic [8:0] PAL_ACTIVE_LAST   = 9'd308;

   localparam logic [8:0] NTSC_SHORT0_LAST  = 9'd2;
   localparam logic [8:0] NTSC_BROAD_LAST   = 9'd5;
   localparam logic [8:0] NTSC_SHORT1_LAST  = 9'd8;
   localparam logic [8:0] NTSC_BLANK_LAST   = 9'd19;
   localparam logic [8:0] NTSC_ACTIVE_LAST  = 9'd261;

   typedef enum logic [2:0] {
      BROAD,
      BROAD_SHORT,
      SHORT,
      BLANK,
      ACTIVE
   } line_type_e;

   function automatic logic [8:0] frame_lines(input logic ntsc);
      return ntsc ? NTSC_LINES : PAL_LINES;
   endfunction

endpackage

// File: rtl/video_line_classifier.sv
// Combinational map of (mode, field, line) to the line type driving the
// sync pulse shape.
module video_line_classifier
   import video_timing_pkg::*;
(
   input  logic       mode_ntsc,
   input  logic       field,
   input  logic [8:0] line,
   output line_type_e line_type
);

   always_comb begin
      line_type = SHORT;
      // extra line of the odd field carries equalising pulses only
      if (field && (line == frame_lines(mode_ntsc))) begin
         line_type = SHORT;
      end else if (mode_ntsc) begin
         if (line <= NTSC_SHORT0_LAST)      line_type = SHORT;
         else if (line <= NTSC_BROAD_LAST)  line_type = BROAD;
         else if (line <= NTSC_SHORT1_LAST) line_type = SHORT;
         else if (line <= NTSC_BLANK_LAST)  line_type = BLANK;
         else if (line <= NTSC_ACTIVE_LAST) line_type = ACTIVE;
         else                               line_type = SHORT;
      end else begin
         if (line <= PAL_BROAD_LAST)        line_type = BROAD;
         else if (line == PAL_BS_LINE)      line_type = BROAD_SHORT;
         else if (line <= PAL_SHORT_LAST)   line_type = SHORT;
         else if (line <= PAL_ACTIVE_LAST)  line_type = ACTIVE;
         else                               line_type = SHORT;
      end
   end

endmodule

// File: rtl/composite_sync_gen.sv
// PAL/NTSC composite sync generator with pixel column, line and frame-start
// outputs. Interlaced fields are enabled by defining COMPOSITE_INTERLACE_EN.
module composite_sync_gen
   import video_timing_pkg::*;
#(
   parameter int HALF_LINE    = 64,
   parameter int HSYNC_LEN    = 9,
   parameter int ACTIVE_START = 21,
   parameter int ACTIVE_END   = 125,
   parameter int BROAD_LEN    = 55,
   parameter int EQ_LEN       = 5
) (
   input  logic                                        syn_clk,
   input  logic                                        rst_n,
   input  logic                                        mode_ntsc,
   output logic [2:0]                                  sync_signal,
   output logic                                        row_enable,
   output logic                                        vblank,
   output logic [$clog2(ACTIVE_END-ACTIVE_START)-1:0]  pix_x,
   output logic [8:0]                                  line_num,
   output logic                                        frame_start,
   output logic                                        field
);

   localparam int H_W   = $clog2(2*HALF_LINE);
   localparam int PIX_W = $clog2(ACTIVE_END-ACTIVE_START);
   // one spare bit so ACTIVE_END may equal the full line length
   localparam int C_W   = H_W + 1;

   localparam logic [C_W-1:0] H_LAST_C = C_W'(2*HALF_LINE-1);
   localparam logic [C_W-1:0] HALF_C   = C_W'(HALF_LINE);
   localparam logic [C_W-1:0] HSYNC_C  = C_W'(HSYNC_LEN);
   localparam logic [C_W-1:0] AST_C    = C_W'(ACTIVE_START);
   localparam logic [C_W-1:0] AEND_C   = C_W'(ACTIVE_END);
   localparam logic [C_W-1:0] BROAD_C  = C_W'(BROAD_LEN);
   localparam logic [C_W-1:0] EQ_C     = C_W'(EQ_LEN);

   logic [H_W-1:0]   h_q, h_d;
   logic [8:0]       line_q, line_d;
   logic             mode_q, mode_d;
   logic             field_q;
   logic [8:0]       last_line;
   line_type_e       line_type;

   logic [C_W-1:0]   h_c, hp_c;
   logic             in_sync, in_active;

   logic [2:0]       sync_q, sync_d;
   logic             row_q, row_d;
   logic             vblank_q, vblank_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic [8:0]       line_num_q, line_num_d;
   logic             fs_q, fs_d;
   logic             field_out_q, field_out_d;

`ifdef COMPOSITE_INTERLACE_EN
   logic             field_d;
   assign last_line = frame_lines(mode_q) - 9'd1 + {8'd0, field_q};
`else
   assign field_q   = 1'b0;
   assign last_line = frame_lines(mode_q) - 9'd1;
`endif

   video_line_classifier u_classifier (
      .mode_ntsc (mode_q),
      .field     (field_q),
      .line      (line_q),
      .line_type (line_type)
   );

   assign h_c  = {1'b0, h_q};
   assign hp_c = (h_c >= HALF_C) ? (h_c - HALF_C) : h_c;

   always_comb begin
      h_d    = h_q + H_W'(1);
      line_d = line_q;
      mode_d = mode_q;
`ifdef COMPOSITE_INTERLACE_EN
      field_d = field_q;
`endif
      if (h_c == H_LAST_C) begin
         h_d = '0;
         if (line_q == last_line) begin
            line_d = '0;
            mode_d = mode_ntsc;
`ifdef COMPOSITE_INTERLACE_EN
            field_d = ~field_q;
`endif
         end else begin
            line_d = line_q + 9'd1;
         end
      end
   end

   always_comb begin
      in_sync   = 1'b0;
      in_active = 1'b0;
      case (line_type)
         BROAD:       in_sync = (hp_c < BROAD_C);
         BROAD_SHORT: in_sync = (h_c < HALF_C) ? (hp_c < BROAD_C) : (hp_c < EQ_C);
         SHORT:       in_sync = (hp_c < EQ_C);
         BLANK:       in_sync = (h_c < HSYNC_C);
         ACTIVE: begin
            in_sync   = (h_c < HSYNC_C);
            in_active = (h_c >= AST_C) && (h_c < AEND_C);
         end
         default: ;
      endcase
      sync_d      = (in_sync && !in_active) ? LVL_SYNC : LVL_BLACK;
      row_d       = in_active;
      pix_d       = in_active ? PIX_W'(h_c - AST_C) : '0;
      vblank_d    = (line_type != ACTIVE);
      line_num_d  = line_q;
      fs_d        = (h_q == '0) && (line_q == '0);
      field_out_d = field_q;
   end

   always_ff @(posedge syn_clk) begin
      if (!rst_n) begin
         h_q         <= '0;
         line_q      <= '0;
         mode_q      <= mode_ntsc;
         sync_q      <= LVL_BLACK;
         row_q       <= 1'b0;
         vblank_q    <= 1'b1;
         pix_q       <= '0;
         line_num_q  <= '0;
         fs_q        <= 1'b0;
         field_out_q <= 1'b0;
`ifdef COMPOSITE_INTERLACE_EN
         field_q     <= 1'b0;
`endif
      end else begin
         h_q         <= h_d;
         line_q      <= line_d;
         mode_q      <= mode_d;
         sync_q      <= sync_d;
         row_q       <= row_d;
         vblank_q    <= vblank_d;
         pix_q       <= pix_d;
         line_num_q  <= line_num_d;
         fs_q        <= fs_d;
         field_out_q <= field_out_d;
`ifdef COMPOSITE_INTERLACE_EN
         field_q     <= field_d;
`endif
      end
   end

   assign sync_signal = sync_q;
   assign row_enable  = row_q;
   assign vblank      = vblank_q;
   assign pix_x       = pix_q;
   assign line_num    = line_num_q;
   assign frame_start = fs_q;
   assign field       = field_out_q;

endmodule

// File: doc/composite_sync_gen.md
Name: composite_sync_gen

Overview:
- Parametrised successor to the fixed PAL composite sync generator.
- Drives the 3-bit video level bus and the row/pixel timing for the pixel pipeline.
- Supports PAL (312-line) and NTSC (262-line) progressive modes, chosen at runtime and latched per frame.
- Adds pixel column and line outputs plus a frame-start strobe; horizontal timing is parameter-driven.

Parameters:
- HALF_LINE, 64, syn_clk ticks per half line; full line = 2*HALF_LINE.
- HSYNC_LEN, 9, normal line sync length in ticks.
- ACTIVE_START, 21, first tick of active video.
- ACTIVE_END, 125, first tick after active video; must be <= 2*HALF_LINE.
- BROAD_LEN, 55, sync length of a broad (vertical) pulse per half line.
- EQ_LEN, 5, sync length of an equalising (short) pulse per half line.

Ports:
- syn_clk  in  1  timing clock (0.5 us tick at defaults)
- rst_n  in  1  synchronous reset, active low
- mode_ntsc  in  1  0=PAL 312 lines, 1=NTSC 262 lines; sampled only at frame wrap
- sync_signal  out  3  video level code (sync=000, black=001)
- row_enable  out  1  high during active pixels of active lines
- vblank  out  1  high outside active lines
- pix_x  out  $clog2(ACTIVE_END-ACTIVE_START)  active column, 0 when row_enable low
- line_num  out  9  current line counter
- frame_start  out  1  one-cycle pulse on the first tick of line 0
- field  out  1  field parity; tied 0 without INTERLACE_EN

Behaviour:
- Reset (rst_n=0 at a syn_clk edge): h counter=0, line=0, mode latch=mode_ntsc, sync_signal=black, row_enable=0, vblank=1, pix_x=0, line_num=0, frame_start=0, field=0.
- h counter runs 0..2*HALF_LINE-1, then wraps and increments the line counter.
- Line counter wraps at LINES-1: PAL 312, NTSC 262.
- Mode latch updates only on that wrap; a mid-frame change of mode_ntsc is ignored until the next frame.
- Outputs are registered and reflect counter state with 1-cycle latency.
- hp = h mod HALF_LINE. "Broad" = sync while hp < BROAD_LEN, else black. "Short" = sync while hp < EQ_LEN, else black.
- PAL line types:
  - lines 0-1 broad;
  - line 2: first half broad, second half short;
  - lines 3-4 short;
  - lines 5-308 active;
  - lines 309-311 short.
- NTSC line types:
  - lines 0-2 short;
  - lines 3-5 broad;
  - lines 6-8 short;
  - lines 9-19 blank (normal hsync, no active video);
  - lines 20-261 active.
- Active / blank line:
  - sync for h < HSYNC_LEN, black otherwise;
  - on active lines only, row_enable=1 for ACTIVE_START <= h < ACTIVE_END, with pix_x = h - ACTIVE_START.
- row_enable is forced 0 on every non-active tick and line; sync_signal is black while row_enable=1. Downstream muxes pixel levels.
- vblank=0 exactly on active lines, updated at the line's first tick.
- frame_start asserts the cycle sync_signal reflects line 0, h 0.

Optional Feature:
- COMPOSITE_INTERLACE_EN defined:
  - field toggles at each frame wrap;
  - when field=1, the frame gets one extra line (PAL 313, NTSC 263) with line_num = LINES, all-short pulses;
  - frame_start still marks line 0 of each field.
- Undefined: progressive only; field constant 0.

Decomposition:
- Shared package video_timing_pkg holds:
  - video level codes sync/black/gray0-5;
  - PAL/NTSC line-count and line-range constants;
  - a line-type enum: BROAD, BROAD_SHORT, SHORT, BLANK, ACTIVE.
- One sub-module, video_line_classifier: combinational map of (mode, field, line) to line type.
- Counters and output registers stay in the top module.

Test Plan:
- Reset held 3 cycles mid-frame, then released -> all outputs at reset values; line_num=0 and frame_start=1 one cycle after release.
- PAL line 0 -> sync_signal=000 for h 0-54 and 64-118, 001 elsewhere.
- PAL line 2 -> sync for h 0-54 and 64-68.
- PAL line 100 -> sync for h 0-8, black for h 9-20, row_enable for h 21-124 with pix_x 0-103, black for h 125-127.
- Free run -> frame_start period 312*128 = 39936 cycles in PAL and 262*128 = 33536 cycles in NTSC.
- vblank rises at line 309 (PAL) and at line 0 (NTSC).
- mode_ntsc toggled at PAL line 150 -> PAL timing continues to line 311, then NTSC from line 0.
- With COMPOSITE_INTERLACE_EN -> alternating 312/313-line PAL fields; field toggles each frame_start.
